pwm_compare_core: RTL and testbench

- Duty-cycle generator that sits directly downstream of the free-running counter stage in the PWM project.
- Owns its own prescaled period counter and compares it against a programmable duty value to drive one PWM pin.
- Takes configuration through a valid/ready handshake into a shadow register, so updates land glitch-free at the period boundary.
- Drives one bit of uo_out at the top level; period_end can feed the next channel or a status pin.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_prescaler.sv | 20 ++
 rtl/pwm_compare_core.sv | 61 ++++++
 tb/tb_pwm_compare_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, configuration record and its reset value for the PWM compare channel
package pwm_pkg;
    localparam int PWM_WIDTH = 8;
    localparam int PWM_PRE_W = 4;
    typedef struct packed {
        logic [PWM_WIDTH-1:0] top;
        logic [PWM_WIDTH-1:0] duty;
        logic [PWM_PRE_W-1:0] div;
        logic                 pol;
    } pwm_cfg_t;
    localparam pwm_cfg_t PWM_CFG_RST = '{top: '1, duty: '0, div: '0, pol: 1'b0};
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divide-by-(div+1) tick generator with synchronous clear and enable
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRE_W = PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);
    logic [PRE_W-1:0] pre;
    assign tick = en & ~clr & (pre == div);
    always_ff @(posedge clk) begin
        if (rst || clr) pre <= '0;
        else if (en) pre <= tick ? '0 : pre + 1'b1;
    end
endmodule

// File: rtl/pwm_compare_core.sv
// pwm_compare_core: prescaled period counter compared against a shadowed duty value to drive one PWM pin
module pwm_compare_core
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int PRE_W = PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_top,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [PRE_W-1:0] cfg_div,
    input  logic             cfg_pol,
    output logic             pwm_out,
    output logic             period_end,
    output logic [WIDTH-1:0] cnt
);
    pwm_cfg_t active, shadow;
    logic     pending, tick, wrap;
    assign cfg_ready = ~pending;
    assign wrap      = tick & (cnt == active.top);
    pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk (clk),
        .rst (rst),
        .clr (~en),
        .en  (en),
        .div (active.div),
        .tick(tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            active     <= PWM_CFG_RST;
            shadow     <= PWM_CFG_RST;
            pending    <= 1'b0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            if (!en) begin
                cnt        <= '0;
                pwm_out    <= active.pol;
                period_end <= 1'b0;
            end else begin
                pwm_out    <= (cnt < active.duty) ^ active.pol;
                period_end <= wrap;
                if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
            end
            if (pending && (!en || wrap)) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (cfg_valid && !pending) begin
                shadow  <= '{top: cfg_top, duty: cfg_duty, div: cfg_div, pol: cfg_pol};
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_compare_core.sv
// tb_pwm_compare_core: scenario tasks checked every cycle against a period-position reference model
module tb_pwm_compare_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, cfg_valid = 1'b0, cfg_pol = 1'b0;
    logic [7:0] cfg_top = '0, cfg_duty = '0;
    logic [3:0] cfg_div = '0;
    logic       cfg_ready, pwm_out, period_end;
    logic [7:0] cnt;
    logic [10:0] obs;
    localparam logic [10:0] RST_VEC = 11'b0_0_00000000_1;
    int checks = 0, fails = 0;
    int m_pos, m_top, m_duty, m_div, m_pol, s_top, s_duty, s_div, s_pol;
    bit m_pend, m_pwm, m_pe;

    always #5 clk = ~clk;
    assign obs = {pwm_out, period_end, cnt, cfg_ready};

    pwm_compare_core dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_top(cfg_top), .cfg_duty(cfg_duty), .cfg_div(cfg_div), .cfg_pol(cfg_pol),
        .pwm_out(pwm_out), .period_end(period_end), .cnt(cnt)
    );

    function automatic logic [10:0] exp_vec();
        logic [7:0] c;
        c = 8'(m_pos / (m_div + 1));
        return {m_pwm, m_pe, c, ~m_pend};
    endfunction

    task automatic step();
        int per, cc;
        bit acc, wrap;
        @(posedge clk);
        per  = (m_top + 1) * (m_div + 1);
        cc   = m_pos / (m_div + 1);
        wrap = 0;
        if (rst) begin
            m_pos = 0; m_top = 255; m_duty = 0; m_div = 0; m_pol = 0;
            m_pend = 0; m_pwm = 0; m_pe = 0;
        end else begin
            acc = cfg_valid && !m_pend;
            if (!en) begin
                m_pos = 0; m_pwm = m_pol[0]; m_pe = 0;
            end else begin
                m_pwm = (cc < m_duty) ^ m_pol[0];
                wrap  = (m_pos == per - 1);
                m_pe  = wrap;
                m_pos = wrap ? 0 : m_pos + 1;
            end
            if (m_pend && (!en || wrap)) begin
                m_top = s_top; m_duty = s_duty; m_div = s_div; m_pol = s_pol; m_pend = 0;
            end
            if (acc) begin
                s_top = cfg_top; s_duty = cfg_duty; s_div = cfg_div; s_pol = cfg_pol; m_pend = 1;
            end
        end
        #1;
    endtask

    task automatic offer(int t, int d, int v, int p);
        cfg_top = 8'(t); cfg_duty = 8'(d); cfg_div = 4'(v); cfg_pol = p[0];
        cfg_valid = 1'b1;
        for (int k = 0; k < 5000 && !cfg_ready; k++) step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL offer_timeout cfg_ready=%b required=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        step(); step();
        checks++;
        if (obs !== RST_VEC) begin fails++; $display("FAIL reset got=%h required=%h", obs, RST_VEC); end
        rst = 1'b0;
    endtask

    task automatic test_defaults();
        int pe_cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            pe_cnt += int'(period_end);
            checks++;
            if (obs !== exp_vec()) begin fails++; $display("FAIL defaults cyc=%0d got=%h required=%h", i, obs, exp_vec()); end
        end
        checks++;
        if (pe_cnt != 2) begin fails++; $display("FAIL defaults_pe_count got=%0d required=2", pe_cnt); end
    endtask

    task automatic test_basic();
        int hi = 0;
        en = 1'b0;
        offer(9, 3, 0, 0);
        step();
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            hi += int'(pwm_out);
            checks++;
            if (obs !== exp_vec()) begin fails++; $display("FAIL basic cyc=%0d got=%h required=%h", i, obs, exp_vec()); end
        end
        checks++;
        if (hi != 12) begin fails++; $display("FAIL basic_high_count got=%0d required=12", hi); end
    endtask

    task automatic test_update();
        step(); step(); step();
        offer(9, 7, 0, 0);
        checks++;
        if (cfg_ready !== 1'b0) begin fails++; $display("FAIL update_ready got=%b required=0", cfg_ready); end
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin fails++; $display("FAIL update cyc=%0d got=%h required=%h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_prescale();
        int hi;
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            en = 1'b0;
            offer(4, 2, 3, p);
            step();
            en = 1'b1;
            for (int i = 0; i < 60; i++) begin
                step();
                hi += int'(pwm_out);
                checks++;
                if (obs !== exp_vec()) begin fails++; $display("FAIL prescale pol=%0d cyc=%0d got=%h required=%h", p, i, obs, exp_vec()); end
            end
            checks++;
            if (hi != (p != 0 ? 36 : 24)) begin fails++; $display("FAIL prescale_high pol=%0d got=%0d required=%0d", p, hi, p != 0 ? 36 : 24); end
        end
    endtask

    task automatic test_boundaries();
        int cases [3][2] = '{'{9, 0}, '{9, 10}, '{0, 1}};
        int hi;
        for (int c = 0; c < 3; c++) begin
            hi = 0;
            en = 1'b0;
            offer(cases[c][0], cases[c][1], 0, 0);
            step();
            en = 1'b1;
            for (int i = 0; i < 25; i++) begin
                step();
                hi += int'(pwm_out);
                checks++;
                if (obs !== exp_vec()) begin fails++; $display("FAIL boundary case=%0d cyc=%0d got=%h required=%h", c, i, obs, exp_vec()); end
            end
            checks++;
            if (hi != (c == 0 ? 0 : 25)) begin fails++; $display("FAIL boundary_level case=%0d got=%0d required=%0d", c, hi, c == 0 ? 0 : 25); end
        end
    endtask

    task automatic test_wrap_offer();
        int k;
        en = 1'b0;
        offer(9, 3, 0, 0);
        step();
        en = 1'b1;
        step(); step();
        for (k = 0; k < 100 && m_pos != (m_top + 1) * (m_div + 1) - 1; k++) step();
        checks++;
        if (k >= 100) begin fails++; $display("FAIL wrap_offer_timeout pos=%0d", m_pos); end
        cfg_top = 8'd9; cfg_duty = 8'd6; cfg_div = 4'd0; cfg_pol = 1'b0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({period_end, cfg_ready} !== 2'b10) begin fails++; $display("FAIL wrap_offer_pending got=%b required=10", {period_end, cfg_ready}); end
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin fails++; $display("FAIL wrap_offer cyc=%0d got=%h required=%h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        step(); step(); step();
        offer(5, 5, 1, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== RST_VEC) begin fails++; $display("FAIL reset_mid got=%h required=%h", obs, RST_VEC); end
        en = 1'b0;
        offer(9, 3, 0, 1);
        step();
        en = 1'b1;
        for (int i = 0; i < 13; i++) step();
        en = 1'b0;
        step();
        checks++;
        if ({pwm_out, cnt} !== 9'h100) begin fails++; $display("FAIL idle_level got=%h required=100", {pwm_out, cnt}); end
        checks++;
        if (obs !== exp_vec()) begin fails++; $display("FAIL idle_model got=%h required=%h", obs, exp_vec()); end
    endtask

    task automatic test_random();
        bit acc_now;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 19) != 0);
            if (!cfg_valid && $urandom_range(0, 14) == 0) begin
                cfg_top = 8'($urandom_range(0, 15)); cfg_duty = 8'($urandom_range(0, 17));
                cfg_div = 4'($urandom_range(0, 2)); cfg_pol = 1'($urandom_range(0, 1));
                cfg_valid = 1'b1;
            end
            acc_now = cfg_valid && cfg_ready && !rst;
            step();
            if (acc_now) cfg_valid = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin fails++; $display("FAIL random cyc=%0d got=%h required=%h", i, obs, exp_vec()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_basic();
        test_update();
        test_prescale();
        test_boundaries();
        test_wrap_offer();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
